// File: rtl/fcore_trace_scheduler_if.sv
// Trace scheduler stream bundle: core record input, DMA write input and
// the shared trace output stream. The master side is the scheduler; the
// slave side is the surrounding core taps, DMA snooper and trace sink.
interface fcore_trace_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 16
);
  // Core instruction records (valid/ready)
  logic                  core_valid;
  logic [DATA_WIDTH-1:0] core_data;
  logic                  core_ready;

  // DMA write snoop (no backpressure)
  logic                  dma_valid;
  logic [DATA_WIDTH-1:0] dma_data;
  logic [DEST_WIDTH-1:0] dma_dest;

  // Shared trace output stream (valid/ready)
  logic                  trace_valid;
  logic [DATA_WIDTH-1:0] trace_data;
  logic [DEST_WIDTH-1:0] trace_dest;
  logic [1:0]            trace_user;
  logic                  trace_ready;

  modport master (
    input  core_valid, core_data,
    output core_ready,
    input  dma_valid, dma_data, dma_dest,
    output trace_valid, trace_data, trace_dest, trace_user,
    input  trace_ready
  );

  modport slave (
    output core_valid, core_data,
    input  core_ready,
    output dma_valid, dma_data, dma_dest,
    input  trace_valid, trace_data, trace_dest, trace_user,
    output trace_ready
  );
endinterface

// File: rtl/fcore_trace_scheduler.sv
// fCore trace scheduler: arms a capture session, frames each captured
// (optionally decimated) round with start/end markers, and shares one
// registered trace output between core records and buffered DMA writes.
// DMA records are held in a FIFO while a round is open and drained between
// rounds.
module fcore_trace_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEST_WIDTH     = 16,
  parameter int DMA_FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          abort,
  input  logic [15:0]                   n_rounds,
  input  logic [7:0]                    decimation,
  input  logic                          start,
  input  logic                          done,
  fcore_trace_scheduler_if.master       bus,
  output logic                          busy,
  output logic [15:0]                   rounds_captured,
  output logic [15:0]                   overflow_count
);

  localparam int PTR_W = $clog2(DMA_FIFO_DEPTH) + 1;
  localparam int AW    = PTR_W - 1;

  localparam logic [1:0] USER_CORE  = 2'd0;
  localparam logic [1:0] USER_DMA   = 2'd1;
  localparam logic [1:0] USER_START = 2'd2;
  localparam logic [1:0] USER_END   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_ROUND = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Session bookkeeping
  logic [7:0]  r_decim_cnt;
  logic [15:0] r_rounds_captured;
  logic [15:0] r_overflow_count;
  logic        r_start_pending;
  logic        r_end_pending;

  // Output register
  logic                  r_trace_valid;
  logic [DATA_WIDTH-1:0] r_trace_data;
  logic [DEST_WIDTH-1:0] r_trace_dest;
  logic [1:0]            r_trace_user;

  // DMA FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [DATA_WIDTH-1:0] r_fifo_data [DMA_FIFO_DEPTH];
  logic [DEST_WIDTH-1:0] r_fifo_dest [DMA_FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;

  // Combinational decode
  logic        w_slot_free;
  logic        w_fifo_empty;
  logic        w_fifo_full;
  logic        w_in_round;
  logic        w_core_ready;
  logic        w_core_fire;
  logic        w_load_start;
  logic        w_end_fire;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_start_take;
  logic [7:0]  w_decim_max;
  logic [7:0]  w_decim_next;
  logic [15:0] w_rounds_next;
  logic        w_last_round;

  assign w_slot_free  = !r_trace_valid || bus.trace_ready;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_in_round   = (r_state == S_ROUND);

  // Inside a round the start marker goes first, then core records; the end
  // marker waits for a gap in the core stream.
  assign w_load_start = w_in_round && r_start_pending && w_slot_free;
  assign w_core_ready = w_in_round && w_slot_free && !r_start_pending;
  assign w_core_fire  = w_core_ready && bus.core_valid;
  assign w_end_fire   = w_in_round && w_slot_free && !r_start_pending &&
                        !bus.core_valid && r_end_pending;

  // DMA records only drain between rounds, never inside one.
  assign w_pop  = ((r_state == S_ARMED) || (r_state == S_DRAIN)) &&
                  !w_fifo_empty && w_slot_free;
  assign w_push = bus.dma_valid && (r_state != S_IDLE) && (!w_fifo_full || w_pop);
  assign w_drop = bus.dma_valid && (r_state != S_IDLE) && w_fifo_full && !w_pop;

  // Decimation: capture the round whose start arrives with the counter at 0.
  assign w_start_take = (r_state == S_ARMED) && start;
  assign w_decim_max  = (decimation == 8'd0) ? 8'd1 : decimation;
  assign w_decim_next = ({1'b0, r_decim_cnt} + 9'd1 >= {1'b0, w_decim_max}) ?
                        8'd0 : r_decim_cnt + 8'd1;

  assign w_rounds_next = (r_rounds_captured == 16'hFFFF) ? 16'hFFFF :
                         r_rounds_captured + 16'd1;
  assign w_last_round  = (n_rounds != 16'd0) && (w_rounds_next == n_rounds);

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; abort overrides every transition
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (arm) w_next_state = S_ARMED;
        S_ARMED: if (start && (r_decim_cnt == 8'd0)) w_next_state = S_ROUND;
        S_ROUND: if (w_end_fire) w_next_state = w_last_round ? S_DRAIN : S_ARMED;
        S_DRAIN: if (w_fifo_empty && w_slot_free) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Session counters, decimation counter and marker-pending flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_decim_cnt       <= 8'd0;
      r_rounds_captured <= 16'd0;
      r_overflow_count  <= 16'd0;
      r_start_pending   <= 1'b0;
      r_end_pending     <= 1'b0;
    end else if (abort) begin
      r_start_pending <= 1'b0;
      r_end_pending   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && arm) begin
        r_decim_cnt       <= 8'd0;
        r_rounds_captured <= 16'd0;
        r_overflow_count  <= 16'd0;
        r_end_pending     <= 1'b0;
      end
      if (w_start_take) begin
        r_decim_cnt <= w_decim_next;
        if (r_decim_cnt == 8'd0) r_start_pending <= 1'b1;
      end
      if (w_load_start) r_start_pending <= 1'b0;
      if (w_in_round && done) r_end_pending <= 1'b1;
      // Emitting the end marker closes the round; it wins over a late done.
      if (w_end_fire) begin
        r_end_pending     <= 1'b0;
        r_rounds_captured <= w_rounds_next;
      end
      if (w_drop && (r_overflow_count != 16'hFFFF))
        r_overflow_count <= r_overflow_count + 16'd1;
    end
  end

  // DMA FIFO pointers; abort flushes by realigning both pointers
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // DMA FIFO storage write
  // NOTE: the storage array has no reset; pointers alone define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clock) begin
    if (w_push && !abort) begin
      r_fifo_data[r_wr_ptr[AW-1:0]] <= bus.dma_data;
      r_fifo_dest[r_wr_ptr[AW-1:0]] <= bus.dma_dest;
    end
  end

  // Output register: load by priority when the slot is free, else hold
  always_ff @(posedge clock) begin
    if (reset) begin
      r_trace_valid <= 1'b0;
      r_trace_data  <= '0;
      r_trace_dest  <= '0;
      r_trace_user  <= USER_CORE;
    end else if (abort) begin
      r_trace_valid <= 1'b0;
    end else if (w_slot_free) begin
      r_trace_valid <= w_load_start || w_core_fire || w_end_fire || w_pop;
      if (w_load_start) begin
        r_trace_data <= '0;
        r_trace_dest <= '0;
        r_trace_user <= USER_START;
      end else if (w_core_fire) begin
        r_trace_data <= bus.core_data;
        r_trace_dest <= '0;
        r_trace_user <= USER_CORE;
      end else if (w_end_fire) begin
        r_trace_data <= DATA_WIDTH'(w_rounds_next);
        r_trace_dest <= '0;
        r_trace_user <= USER_END;
      end else if (w_pop) begin
        r_trace_data <= r_fifo_data[r_rd_ptr[AW-1:0]];
        r_trace_dest <= r_fifo_dest[r_rd_ptr[AW-1:0]];
        r_trace_user <= USER_DMA;
      end
    end
  end

  assign bus.core_ready   = w_core_ready;
  assign bus.trace_valid  = r_trace_valid;
  assign bus.trace_data   = r_trace_data;
  assign bus.trace_dest   = r_trace_dest;
  assign bus.trace_user   = r_trace_user;
  assign busy             = (r_state != S_IDLE);
  assign rounds_captured  = r_rounds_captured;
  assign overflow_count   = r_overflow_count;

endmodule

// File: tb/tb_fcore_trace_scheduler.sv
// Scoreboard bench for fcore_trace_scheduler: stimulus tasks push expected
// trace beats into a queue; an independent monitor pops and compares on
// every output handshake and checks hold-while-stalled behaviour.
module tb_fcore_trace_scheduler;

  localparam int DW    = 32;
  localparam int DEW   = 16;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        arm, abort, start, done;
  logic [15:0] n_rounds;
  logic [7:0]  decimation;
  logic        busy;
  logic [15:0] rounds_captured;
  logic [15:0] overflow_count;

  fcore_trace_scheduler_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DEW)) bus ();

  fcore_trace_scheduler #(
    .DATA_WIDTH(DW), .DEST_WIDTH(DEW), .DMA_FIFO_DEPTH(DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .arm             (arm),
    .abort           (abort),
    .n_rounds        (n_rounds),
    .decimation      (decimation),
    .start           (start),
    .done            (done),
    .bus             (bus),
    .busy            (busy),
    .rounds_captured (rounds_captured),
    .overflow_count  (overflow_count)
  );

  always #5 clock = ~clock;

  typedef logic [49:0] beat_t;  // {user[1:0], dest[15:0], data[31:0]}

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t dma_q[$];
  int    exp_rounds = 0;

  function automatic beat_t mk(input logic [1:0] u, input logic [15:0] d,
                               input logic [31:0] v);
    return {u, d, v};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every handshaken beat and check stall behaviour
  initial begin : monitor
    logic  stall;
    beat_t held;
    beat_t cur;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clock);
      cur = {bus.trace_user, bus.trace_dest, bus.trace_data};
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall)
          check("stall_hold", {13'd0, bus.trace_valid, cur}, {13'd0, 1'b1, held});
        if (bus.trace_valid && !bus.trace_ready)
          check("stall_core_ready", {63'd0, bus.core_ready}, 64'd0);
        if (bus.trace_valid && bus.trace_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected none", cur);
          end else begin
            check("trace_beat", {14'd0, cur}, {14'd0, exp_q.pop_front()});
          end
        end
        stall = bus.trace_valid && !bus.trace_ready;
        held  = cur;
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic arm_session(input logic [15:0] n, input logic [7:0] dec);
    n_rounds   = n;
    decimation = dec;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    exp_rounds = 0;
  endtask

  task automatic pulse_start(input bit framed);
    start = 1'b1;
    if (framed) exp_q.push_back(mk(2'd2, 16'd0, 32'd0));
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done(input bit framed);
    done = 1'b1;
    if (framed) begin
      exp_rounds++;
      exp_q.push_back(mk(2'd3, 16'd0, 32'(exp_rounds)));
      while (dma_q.size() > 0) exp_q.push_back(dma_q.pop_front());
    end
    tick();
    done = 1'b0;
  endtask

  task automatic send_core(input logic [31:0] d);
    bit got;
    got = 1'b0;
    bus.core_valid = 1'b1;
    bus.core_data  = d;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clock);
      if (bus.core_ready) got = 1'b1;
      @(posedge clock);
      #1;
    end
    bus.core_valid = 1'b0;
    if (got) exp_q.push_back(mk(2'd0, 16'd0, d));
    else     check("core_accept_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic dma_burst(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.dma_valid = 1'b1;
      bus.dma_data  = base + 32'(i);
      bus.dma_dest  = 16'h0100 + 16'(i);
      if (dma_q.size() < DEPTH)
        dma_q.push_back(mk(2'd1, 16'h0100 + 16'(i), base + 32'(i)));
      tick();
    end
    bus.dma_valid = 1'b0;
  endtask

  task automatic run_round(input int nbeats, input logic [31:0] base);
    pulse_start(1'b1);
    for (int i = 0; i < nbeats; i++) send_core(base + 32'(i));
    pulse_done(1'b1);
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || bus.trace_valid) && c < 300) begin
      @(negedge clock);
      c++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    arm            = 1'b0;
    abort          = 1'b0;
    start          = 1'b0;
    done           = 1'b0;
    n_rounds       = 16'd0;
    decimation     = 8'd1;
    bus.core_valid = 1'b0;
    bus.core_data  = '0;
    bus.dma_valid  = 1'b0;
    bus.dma_data   = '0;
    bus.dma_dest   = '0;
    bus.trace_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_trace_valid", {63'd0, bus.trace_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rounds", 64'(rounds_captured), 64'd0);
    check("rst_overflow", 64'(overflow_count), 64'd0);
    check("rst_core_ready", {63'd0, bus.core_ready}, 64'd0);
    tick();

    // DMA writes in IDLE are ignored (monitor flags any stray beat)
    dma_burst(3, 32'hDEAD_0000);
    dma_q.delete();
    check("idle_dma_overflow", 64'(overflow_count), 64'd0);

    // T1: two framed rounds of three core beats
    arm_session(16'd2, 8'd1);
    run_round(3, 32'hA000_0000);
    wait_drain("t1_round1_drain");
    check("t1_busy_mid", {63'd0, busy}, 64'd1);
    check("t1_rounds_mid", 64'(rounds_captured), 64'd1);
    run_round(3, 32'hA100_0000);
    wait_drain("t1_round2_drain");
    check("t1_busy_end", {63'd0, busy}, 64'd0);
    check("t1_rounds_end", 64'(rounds_captured), 64'd2);

    // T2: decimation 3, four starts: rounds 1 and 4 captured
    arm_session(16'd2, 8'd3);
    run_round(2, 32'hB000_0000);
    wait_drain("t2_first_drain");
    for (int s = 0; s < 2; s++) begin
      pulse_start(1'b0);
      bus.core_valid = 1'b1;
      bus.core_data  = 32'hBAD0_0000;
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        check("t2_skip_core_ready", {63'd0, bus.core_ready}, 64'd0);
        tick();
      end
      bus.core_valid = 1'b0;
      pulse_done(1'b0);
    end
    check("t2_rounds_skipped", 64'(rounds_captured), 64'd1);
    run_round(1, 32'hB100_0000);
    wait_drain("t2_last_drain");
    check("t2_rounds_end", 64'(rounds_captured), 64'd2);
    check("t2_busy_end", {63'd0, busy}, 64'd0);

    // T3: three DMA writes inside a round, drained after the end marker
    arm_session(16'd1, 8'd1);
    pulse_start(1'b1);
    send_core(32'hC000_0001);
    dma_burst(3, 32'hD000_0000);
    send_core(32'hC000_0002);
    pulse_done(1'b1);
    wait_drain("t3_drain");
    check("t3_overflow", 64'(overflow_count), 64'd0);
    check("t3_busy_end", {63'd0, busy}, 64'd0);

    // T4: 20 DMA writes into a 16-deep FIFO
    arm_session(16'd1, 8'd1);
    pulse_start(1'b1);
    dma_burst(20, 32'hE000_0000);
    pulse_done(1'b1);
    wait_drain("t4_drain");
    check("t4_overflow", 64'(overflow_count), 64'd4);
    check("t4_rounds", 64'(rounds_captured), 64'd1);

    // T5: sink stalls five cycles mid-round
    arm_session(16'd1, 8'd1);
    pulse_start(1'b1);
    send_core(32'hF000_0001);
    bus.trace_ready = 1'b0;
    bus.core_valid  = 1'b1;
    bus.core_data   = 32'hF000_0002;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("t5_core_ready", {63'd0, bus.core_ready}, 64'd0);
      tick();
    end
    bus.trace_ready = 1'b1;
    send_core(32'hF000_0002);
    send_core(32'hF000_0003);
    pulse_done(1'b1);
    wait_drain("t5_drain");

    // T6: abort mid-round with DMA buffered, then a clean session
    arm_session(16'd0, 8'd1);
    pulse_start(1'b1);
    send_core(32'h6000_0001);
    dma_burst(3, 32'h6600_0000);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
    check("t6_pre_abort_queue", 64'(exp_q.size()), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    dma_q.delete();
    @(negedge clock);
    check("t6_busy_after_abort", {63'd0, busy}, 64'd0);
    check("t6_valid_after_abort", {63'd0, bus.trace_valid}, 64'd0);
    check("t6_rounds_hold", 64'(rounds_captured), 64'd0);
    repeat (5) tick();
    arm_session(16'd1, 8'd1);
    run_round(2, 32'h7000_0000);
    wait_drain("t6_clean_drain");
    check("t6_rounds_clean", 64'(rounds_captured), 64'd1);
    check("t6_overflow_clean", 64'(overflow_count), 64'd0);
    check("t6_busy_end", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
